// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter letting four byte requesters share one UART transmitter.
// Optional WAIT_DONE abort timer is compiled in with `define UART_TX_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int          NUM_REQ        = 4,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic                 pClk,
    input  logic                 pReset,
    input  logic                 enable,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic                 TxDone,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 TxEn,
    output logic [7:0]           TxData,
    output logic                 busy,
    output logic [1:0]           owner,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t             state, stateNxt;
    logic [NUM_REQ-1:0] gntNxt;
    logic               txEnNxt;
    logic [7:0]         txDataNxt;
    logic               busyNxt;
    logic [1:0]         ownerNxt;
    logic               timeoutNxt;
    logic [1:0]         winner;

`ifdef UART_TX_TIMEOUT_EN
    logic [15:0]        waitCnt, waitCntNxt;
`endif

    if (TIMEOUT_CYCLES == 16'd0) begin : gBadTimeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    // Nearest requesting index above the last owner, wrapping back to the owner itself.
    function automatic logic [1:0] pickWinner(input logic [NUM_REQ-1:0] r, input logic [1:0] last);
        logic       found;
        logic [1:0] idx;
        found      = 1'b0;
        pickWinner = last;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = last + k[1:0];
            if (!found && r[idx]) begin
                pickWinner = idx;
                found      = 1'b1;
            end
        end
    endfunction

    always_comb begin
        stateNxt   = state;
        gntNxt     = '0;
        txEnNxt    = 1'b0;
        txDataNxt  = TxData;
        ownerNxt   = owner;
        timeoutNxt = 1'b0;
        winner     = pickWinner(req, owner);
`ifdef UART_TX_TIMEOUT_EN
        waitCntNxt = waitCnt;
`endif
        unique case (state)
            IDLE: begin
                if (enable && (|req)) begin
                    stateNxt       = START;
                    txDataNxt      = req_data[8*winner +: 8];
                    ownerNxt       = winner;
                    gntNxt[winner] = 1'b1;
                    txEnNxt        = 1'b1;
                end
            end
            START: begin
                stateNxt = WAIT_DONE;
`ifdef UART_TX_TIMEOUT_EN
                waitCntNxt = '0;
`endif
            end
            WAIT_DONE: begin
                if (TxDone) begin
                    stateNxt = IDLE;
`ifdef UART_TX_TIMEOUT_EN
                end else if (waitCnt == TIMEOUT_CYCLES - 16'd1) begin
                    stateNxt   = IDLE;
                    timeoutNxt = 1'b1;
                end else begin
                    waitCntNxt = waitCnt + 16'd1;
`endif
                end
            end
            default: stateNxt = IDLE;
        endcase
        busyNxt = (stateNxt != IDLE);
    end

    // Registered outputs are loaded from the next-state decode so they align with the state.
    always_ff @(posedge pClk) begin
        if (!pReset) begin
            state       <= IDLE;
            gnt         <= '0;
            TxEn        <= 1'b0;
            TxData      <= 8'h00;
            busy        <= 1'b0;
            owner       <= 2'd3;
            timeout_err <= 1'b0;
        end else begin
            state       <= stateNxt;
            gnt         <= gntNxt;
            TxEn        <= txEnNxt;
            TxData      <= txDataNxt;
            busy        <= busyNxt;
            owner       <= ownerNxt;
            timeout_err <= timeoutNxt;
        end
    end

`ifdef UART_TX_TIMEOUT_EN
    always_ff @(posedge pClk) begin
        if (!pReset) begin
            waitCnt <= '0;
        end else begin
            waitCnt <= waitCntNxt;
        end
    end
`endif

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of byte requesters sharing one UART transmitter (fixed 4 in this revision).
REQ-002 Parameter TIMEOUT_CYCLES, 16'd50000, pClk cycles allowed in WAIT_DONE before abort (used only with UART_TX_TIMEOUT_EN).
REQ-003 pClk  input  1  single clock; all logic on rising edge.
REQ-004 pReset  input  1  synchronous, active-low reset.
REQ-005 enable  input  1  arbitration enable; low blocks new grants only.
REQ-006 req  input  4  per-requester request, level, held until granted.
REQ-007 req_data  input  32  packed bytes; requester i owns bits [8i+7:8i], stable while req[i] high.
REQ-008 TxDone  input  1  single-cycle pulse from transmitter at end of frame.
REQ-009 gnt  output  4  one-hot, one-cycle pulse: requester's byte accepted.
REQ-010 TxEn  output  1  one-cycle start pulse to transmitter.
REQ-011 TxData  output  8  registered byte to transmit; held until next grant.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 owner  output  2  index of last granted requester.
REQ-014 timeout_err  output  1  one-cycle pulse on transfer abort.

Function
REQ-015 FSM states IDLE, START, WAIT_DONE; all outputs registered.
REQ-016 IDLE: if enable and any req bit high, next state START; else stay IDLE.
REQ-017 Winner = first set req bit searching upward (modulo 4) from owner+1; with owner=3 after reset, requester 0 has top priority.
REQ-018 IDLE->START transition: load TxData with winner's byte, owner <= winner.
REQ-019 START (exactly one cycle): gnt[owner]=1 and TxEn=1, then WAIT_DONE.
REQ-020 Latency: req sampled high in IDLE at cycle N -> gnt/TxEn high at N+1 -> WAIT_DONE at N+2.
REQ-021 WAIT_DONE: stay until TxDone=1; on TxDone, next state IDLE.
REQ-022 TxDone in IDLE or START ignored; no state or output change.
REQ-023 Request dropped before grant: no grant issued, no other effect.
REQ-024 Requester holding req after gnt is treated as a new request; it re-competes in the next IDLE under round-robin.
REQ-025 Same-cycle requests: exactly one grant per transfer; never two gnt bits high.
REQ-026 enable low during START/WAIT_DONE: transfer completes normally; arbitration in IDLE blocked until enable high.
REQ-027 Minimum spacing between consecutive TxEn pulses: 3 cycles (START, WAIT_DONE with TxDone, IDLE).

Reset
REQ-028 pReset low at a rising edge: state IDLE, gnt=0, TxEn=0, TxData=8'h00, busy=0, owner=2'd3, timeout_err=0, timeout counter=0.
REQ-029 Reset mid-transfer aborts immediately; no gnt, TxEn or timeout_err issued for the aborted transfer.

Configuration
REQ-030 Macro UART_TX_TIMEOUT_EN defined: a counter clears on WAIT_DONE entry and increments each WAIT_DONE cycle without TxDone; at TIMEOUT_CYCLES it forces IDLE and pulses timeout_err for one cycle; TxDone on the same cycle wins (normal completion, no error).
REQ-031 Macro UART_TX_TIMEOUT_EN undefined: no counter, WAIT_DONE waits indefinitely, timeout_err tied 0.

Verification
REQ-032 Reset, then req=4'b0001, req_data[7:0]=8'hA5, enable=1 -> next cycle gnt=4'b0001, TxEn=1, TxData=8'hA5; busy=1 until cycle after TxDone.
REQ-033 req=4'b1111 held, bytes 8'h10/8'h11/8'h12/8'h13, TxDone 5 cycles after each TxEn -> TxData order 10,11,12,13,10; gnt order 0,1,2,3,0.
REQ-034 enable=0, req=4'b0100 for 20 cycles -> no gnt, no TxEn; enable=1 -> gnt=4'b0100 next cycle.
REQ-035 TxDone pulse in IDLE and in START -> ignored; FSM leaves WAIT_DONE only on a later TxDone.
REQ-036 With UART_TX_TIMEOUT_EN, TIMEOUT_CYCLES=8, no TxDone -> timeout_err pulses once after 8 WAIT_DONE cycles, busy=0 next cycle; without macro, busy stays 1.
REQ-037 pReset low during WAIT_DONE -> next cycle all outputs at reset values; subsequent req=4'b0010 granted with no stale TxDone effect.
